// File: rtl/stage_queue_pkg.sv
// Shared types and lane-mask helpers for the fetch/decode stage queue.
// Bypass behaviour is selected in stage_queue.sv by the STAGE_QUEUE_BYPASS_EN macro.
package stage_queue_pkg;

    typedef enum logic [1:0] {
        FET_EXC_NONE     = 2'd0,
        FET_EXC_MISALIGN = 2'd1,
        FET_EXC_PAGE     = 2'd2,
        FET_EXC_ACCESS   = 2'd3
    } fet_exc_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] insn;
        fet_exc_t    exc;
        logic        pred_taken;
        logic [6:0]  ghist;
    } fet_bundle_t;

    localparam int unsigned FET_BUNDLE_W = $bits(fet_bundle_t);

    // Lane masks are zero-extended to this width before being handed to the helpers.
    localparam int unsigned MAX_LANES = 32;

    function automatic int unsigned lead_ones(input logic [MAX_LANES-1:0] mask);
        int unsigned n;
        logic        run;
        n   = 0;
        run = 1'b1;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (run && mask[i]) begin
                n = n + 1;
            end else begin
                run = 1'b0;
            end
        end
        return n;
    endfunction

    function automatic int unsigned popcnt(input logic [MAX_LANES-1:0] mask);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_LANES; i++) begin
            n = n + int'(mask[i]);
        end
        return n;
    endfunction

    // True when the set bits form a contiguous run starting at bit 0.
    function automatic logic is_prefix(input logic [MAX_LANES-1:0] mask);
        logic [MAX_LANES:0] plus_one;
        plus_one = {1'b0, mask} + (MAX_LANES+1)'(1);
        return (plus_one[MAX_LANES-1:0] & mask) == '0;
    endfunction

endpackage

// File: rtl/stage_queue_if.sv
// Producer/consumer handshake bundle of the stage queue; master drives the inputs,
// slave is the queue itself.
interface stage_queue_if
    import stage_queue_pkg::*;
#(
    parameter int unsigned WIDTH = FET_BUNDLE_W,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned IWAY  = 4,
    parameter int unsigned OWAY  = 4
)();

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [IWAY-1:0]            i_valid;
    logic [IWAY-1:0][WIDTH-1:0] i_data;
    logic                       i_ready;
    logic [OWAY-1:0]            o_valid;
    logic [OWAY-1:0][WIDTH-1:0] o_data;
    logic [OWAY-1:0]            o_ready;
    logic [CNT_W-1:0]           o_count;

    modport master (
        output i_valid, i_data, o_ready,
        input  i_ready, o_valid, o_data, o_count
    );

    modport slave (
        input  i_valid, i_data, o_ready,
        output i_ready, o_valid, o_data, o_count
    );

endinterface

// File: rtl/stage_queue_lane_compact.sv
// Packs the valid input lanes into a dense prefix (lane order preserved) and
// reports how many lanes were valid.
module lane_compact
    import stage_queue_pkg::*;
#(
    parameter  int unsigned WAY   = 4,
    parameter  int unsigned WIDTH = FET_BUNDLE_W,
    localparam int unsigned NW    = $clog2(WAY) + 1
)(
    input  logic [WAY-1:0]            valid_i,
    input  logic [WAY-1:0][WIDTH-1:0] data_i,
    output logic [WAY-1:0]            valid_o,
    output logic [WAY-1:0][WIDTH-1:0] data_o,
    output logic [NW-1:0]             n_o
);

    genvar gi;

    // Each input lane's rank among the valid lanes selects its output slot.
    always_comb begin
        logic [NW-1:0] rank;
        rank   = '0;
        data_o = '0;
        for (int j = 0; j < WAY; j++) begin
            for (int k = 0; k < WAY; k++) begin
                if (valid_i[j] && (rank == NW'(k))) begin
                    data_o[k] = data_i[j];
                end
            end
            rank = rank + NW'(valid_i[j]);
        end
    end

    assign n_o = NW'(popcnt(MAX_LANES'(valid_i)));

    for (gi = 0; gi < WAY; gi++) begin : g_valid
        assign valid_o[gi] = (n_o > NW'(gi));
    end

endmodule

// File: rtl/stage_queue.sv
// Multi-lane in-order circular queue between two pipeline stages.
// Define STAGE_QUEUE_BYPASS_EN for a zero-latency path through an empty queue.
module stage_queue
    import stage_queue_pkg::*;
#(
    parameter int unsigned WIDTH = FET_BUNDLE_W,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned IWAY  = 4,
    parameter int unsigned OWAY  = 4
)(
    input  logic           clk,
    input  logic           rstn,
    input  logic           flush,
    stage_queue_if.slave   bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned NI_W  = $clog2(IWAY) + 1;

    genvar gi;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [IWAY-1:0]             cmp_valid;
    logic [IWAY-1:0][WIDTH-1:0]  cmp_data;
    logic [NI_W-1:0]             cmp_n;

    logic                        in_ready;
    logic                        enq;
    logic [CNT_W-1:0]            n_in;
    logic [CNT_W-1:0]            take;
    logic [CNT_W-1:0]            skip;
    logic                        bypass;

    logic [OWAY-1:0]             reg_valid;
    logic [OWAY-1:0][WIDTH-1:0]  rd_data;
    logic [OWAY-1:0]             out_valid;
    logic [OWAY-1:0][WIDTH-1:0]  out_data;

    logic [DEPTH-1:0]            wr_en;
    logic [DEPTH-1:0][WIDTH-1:0] wr_data;

    lane_compact #(
        .WAY   (IWAY),
        .WIDTH (WIDTH)
    ) u_compact (
        .valid_i (bus.i_valid),
        .data_i  (bus.i_data),
        .valid_o (cmp_valid),
        .data_o  (cmp_data),
        .n_o     (cmp_n)
    );

    // Space freed by a same-cycle dequeue is deliberately not counted here.
    assign in_ready = (count_q <= CNT_W'(DEPTH - IWAY));
    assign enq      = in_ready && !flush;
    assign n_in     = enq ? CNT_W'(cmp_n) : '0;

    for (gi = 0; gi < OWAY; gi++) begin : g_read
        assign reg_valid[gi] = (count_q > CNT_W'(gi));
        assign rd_data[gi]   = mem_q[head_q + PTR_W'(gi)];
    end

`ifdef STAGE_QUEUE_BYPASS_EN
    logic [OWAY-1:0]            byp_valid;
    logic [OWAY-1:0][WIDTH-1:0] byp_data;

    for (gi = 0; gi < OWAY; gi++) begin : g_byp
        if (gi < IWAY) begin : g_lane
            assign byp_valid[gi] = cmp_valid[gi];
            assign byp_data[gi]  = cmp_data[gi];
        end else begin : g_pad
            assign byp_valid[gi] = 1'b0;
            assign byp_data[gi]  = '0;
        end
    end

    // An empty queue always has room, so the compacted inputs are already accepted.
    assign bypass    = (count_q == '0) && !flush;
    assign out_valid = bypass ? byp_valid : reg_valid;
    assign out_data  = bypass ? byp_data  : rd_data;
`else
    assign bypass    = 1'b0;
    assign out_valid = reg_valid;
    assign out_data  = rd_data;
`endif

    assign take = flush ? '0 : CNT_W'(lead_ones(MAX_LANES'(out_valid & bus.o_ready)));
    // Bundles consumed straight off the bypass never touch storage.
    assign skip = bypass ? take : '0;

    always_comb begin
        logic [PTR_W-1:0] wr_addr;
        wr_addr = '0;
        wr_en   = '0;
        wr_data = '0;
        for (int j = 0; j < IWAY; j++) begin
            if (enq && cmp_valid[j] && (CNT_W'(j) >= skip)) begin
                wr_addr          = tail_q + PTR_W'(CNT_W'(j) - skip);
                wr_en[wr_addr]   = 1'b1;
                wr_data[wr_addr] = cmp_data[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int e = 0; e < DEPTH; e++) begin
            if (wr_en[e]) begin
                mem_q[e] <= wr_data[e];
            end
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + (bypass ? '0 : PTR_W'(take));
            tail_d  = tail_q + PTR_W'(n_in - skip);
            count_d = count_q + n_in - take;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign bus.i_ready = in_ready;
    assign bus.o_valid = out_valid;
    assign bus.o_data  = out_data;
    assign bus.o_count = count_q;

`ifndef SYNTHESIS
    a_o_ready_prefix : assert property (@(posedge clk) disable iff (!rstn)
        is_prefix(MAX_LANES'(bus.o_ready)));
    a_count_bound : assert property (@(posedge clk) disable iff (!rstn)
        count_q <= CNT_W'(DEPTH));
`endif

endmodule

// File: tb/tb_stage_queue.sv
// Directed bench for stage_queue: vector table plus hand sequences for fill,
// wrap, flush and latency/reset corners.
module tb_stage_queue;

    localparam int unsigned W = 106;

    logic clk;
    logic rstn;
    logic flush;

    int tests = 0;
    int fails = 0;

    logic [15:0] model[$];
    logic [15:0] nt;

    stage_queue_if #(.WIDTH(W), .DEPTH(16), .IWAY(4), .OWAY(4)) bus();

    stage_queue #(.WIDTH(W), .DEPTH(16), .IWAY(4), .OWAY(4)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic            fl;
        logic [3:0]      iv;
        logic [3:0][15:0] t;
        logic [3:0]      ordy;
        logic [4:0]      cnt;
        logic [3:0]      ov;
        logic            ir;
        logic [3:0][15:0] et;
    } vec_t;

    vec_t vt[10];

    function automatic vec_t mk(input logic fl, input logic [3:0] iv, input logic [3:0][15:0] t,
                                input logic [3:0] ordy, input logic [4:0] cnt, input logic [3:0] ov,
                                input logic ir, input logic [3:0][15:0] et);
        vec_t v;
        v.fl = fl; v.iv = iv; v.t = t; v.ordy = ordy;
        v.cnt = cnt; v.ov = ov; v.ir = ir; v.et = et;
        return v;
    endfunction

    function automatic logic [W-1:0] bd(input logic [15:0] t);
        return {t, 74'h0, t};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_inputs(input logic fl, input logic [3:0] iv, input logic [3:0][15:0] t,
                              input logic [3:0] ordy);
        flush       = fl;
        bus.i_valid = iv;
        for (int k = 0; k < 4; k++) bus.i_data[k] = bd(t[k]);
        bus.o_ready = ordy;
    endtask

    task automatic post_check(input string tag);
        logic [3:0] m;
        m = '0;
        for (int k = 0; k < 4; k++) if (k < model.size()) m[k] = 1'b1;
        check({tag, " count"}, 128'(bus.o_count), 128'(model.size()));
        check({tag, " o_valid"}, 128'(bus.o_valid), 128'(m));
        check({tag, " i_ready_after"}, 128'(bus.i_ready), 128'((16 - model.size()) >= 4));
        for (int k = 0; k < 4; k++)
            if (k < model.size()) check($sformatf("%s data%0d", tag, k), 128'(bus.o_data[k]), 128'(bd(model[k])));
    endtask

    task automatic run_cycle(input logic fl, input logic [3:0] iv, input logic [3:0][15:0] t,
                             input logic [3:0] ordy, input string tag);
        int   sz;
        int   nout;
        logic ir;
        sz = model.size();
        ir = ((16 - sz) >= 4);
        set_inputs(fl, iv, t, ordy);
        #1;
        check({tag, " i_ready"}, 128'(bus.i_ready), 128'(ir));
        @(posedge clk);
        #1;
        set_inputs(1'b0, 4'b0, '0, 4'b0);
        if (fl) begin
            model.delete();
        end else begin
            nout = 0;
            for (int k = 0; k < 4; k++) if (ordy[k] && (k < sz) && (nout == k)) nout++;
            repeat (nout) void'(model.pop_front());
            if (ir) for (int k = 0; k < 4; k++) if (iv[k]) model.push_back(t[k]);
        end
        #1;
        post_check(tag);
    endtask

    function automatic logic [3:0][15:0] next4();
        logic [3:0][15:0] r;
        r  = {nt + 16'd3, nt + 16'd2, nt + 16'd1, nt};
        nt = nt + 16'd4;
        return r;
    endfunction

    initial begin
        logic [15:0] D;
        D  = 16'hDEAD;
        nt = 16'h0100;

        vt[0] = mk(0, 4'b1011, {16'hC0, 16'hEE, 16'hB0, 16'hA0}, 4'b0000, 5'd3, 4'b0111, 1,
                   {16'h0, 16'hC0, 16'hB0, 16'hA0});
        vt[1] = mk(0, 4'b1111, {16'h4, 16'h3, 16'h2, 16'h1}, 4'b0000, 5'd7, 4'b1111, 1,
                   {16'h1, 16'hC0, 16'hB0, 16'hA0});
        vt[2] = mk(0, 4'b0000, '0, 4'b0011, 5'd5, 4'b1111, 1, {16'h3, 16'h2, 16'h1, 16'hC0});
        vt[3] = mk(0, 4'b1111, {16'h8, 16'h7, 16'h6, 16'h5}, 4'b0011, 5'd7, 4'b1111, 1,
                   {16'h5, 16'h4, 16'h3, 16'h2});
        vt[4] = mk(0, 4'b0100, {D, 16'h9, D, D}, 4'b1111, 5'd4, 4'b1111, 1,
                   {16'h9, 16'h8, 16'h7, 16'h6});
        vt[5] = mk(0, 4'b1111, {16'h13, 16'h12, 16'h11, 16'h10}, 4'b0001, 5'd7, 4'b1111, 1,
                   {16'h10, 16'h9, 16'h8, 16'h7});
        vt[6] = mk(0, 4'b0011, {D, D, 16'h15, 16'h14}, 4'b0000, 5'd9, 4'b1111, 1,
                   {16'h10, 16'h9, 16'h8, 16'h7});
        vt[7] = mk(1, 4'b1111, {16'h31, 16'h32, 16'h33, 16'h34}, 4'b0011, 5'd0, 4'b0000, 1, '0);
        vt[8] = mk(0, 4'b0010, {D, D, 16'h20, D}, 4'b0000, 5'd1, 4'b0001, 1,
                   {16'h0, 16'h0, 16'h0, 16'h20});
        vt[9] = mk(0, 4'b0000, '0, 4'b0001, 5'd0, 4'b0000, 1, '0);

        // Reset state
        rstn = 1'b0;
        set_inputs(1'b0, 4'b0, '0, 4'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset count", 128'(bus.o_count), 128'(0));
        check("reset o_valid", 128'(bus.o_valid), 128'(0));
        check("reset i_ready", 128'(bus.i_ready), 128'(1));
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Vector table: inputs held for one edge, outputs checked after it with inputs idle
        for (int v = 0; v < 10; v++) begin
            set_inputs(vt[v].fl, vt[v].iv, vt[v].t, vt[v].ordy);
            @(posedge clk);
            #1;
            set_inputs(1'b0, 4'b0, '0, 4'b0);
            #1;
            check($sformatf("v%0d count", v), 128'(bus.o_count), 128'(vt[v].cnt));
            check($sformatf("v%0d o_valid", v), 128'(bus.o_valid), 128'(vt[v].ov));
            check($sformatf("v%0d i_ready", v), 128'(bus.i_ready), 128'(vt[v].ir));
            for (int k = 0; k < 4; k++)
                if (vt[v].ov[k])
                    check($sformatf("v%0d data%0d", v, k), 128'(bus.o_data[k]), 128'(bd(vt[v].et[k])));
            $display("[TB] vector %0d applied: iv=%b ordy=%b flush=%b count=%0d", v, vt[v].iv,
                     vt[v].ordy, vt[v].fl, bus.o_count);
        end

        // Fill to 13, rejected push, then take 3
        repeat (3) run_cycle(1'b0, 4'b1111, next4(), 4'b0000, "fill");
        run_cycle(1'b0, 4'b0001, next4(), 4'b0000, "fill13");
        check("fill13 count", 128'(bus.o_count), 128'(13));
        check("fill13 i_ready", 128'(bus.i_ready), 128'(0));
        run_cycle(1'b0, 4'b0001, next4(), 4'b0000, "rejected");
        check("rejected count", 128'(bus.o_count), 128'(13));
        run_cycle(1'b0, 4'b0000, '0, 4'b0111, "take3");
        check("take3 count", 128'(bus.o_count), 128'(10));
        check("take3 i_ready", 128'(bus.i_ready), 128'(1));
        for (int i = 0; i < 8 && model.size() > 0; i++)
            run_cycle(1'b0, 4'b0000, '0, 4'b1111, "drain");
        check("drained", 128'(bus.o_count), 128'(0));

        // 40 bundles streamed 4-in/4-out across the pointer wrap
        run_cycle(1'b0, 4'b1111, next4(), 4'b0000, "wrap_prime");
        for (int i = 0; i < 9; i++)
            run_cycle(1'b0, 4'b1111, next4(), 4'b1111, $sformatf("wrap%0d", i));
        check("wrap steady count", 128'(bus.o_count), 128'(4));
        run_cycle(1'b0, 4'b0000, '0, 4'b1111, "wrap_drain");

        // Latency corner on an empty queue, then async reset mid-stream
        set_inputs(1'b0, 4'b0011, {16'h0, 16'h0, 16'h0E2, 16'h0E1}, 4'b0001);
        #1;
`ifdef STAGE_QUEUE_BYPASS_EN
        check("byp same o_valid", 128'(bus.o_valid), 128'(4'b0011));
        check("byp same data0", 128'(bus.o_data[0]), 128'(bd(16'h0E1)));
        @(posedge clk);
        #1;
        set_inputs(1'b0, 4'b0, '0, 4'b0);
        #1;
        check("byp next o_valid", 128'(bus.o_valid), 128'(4'b0001));
        check("byp next data0", 128'(bus.o_data[0]), 128'(bd(16'h0E2)));
        check("byp next count", 128'(bus.o_count), 128'(1));
`else
        check("lat same o_valid", 128'(bus.o_valid), 128'(4'b0000));
        @(posedge clk);
        #1;
        set_inputs(1'b0, 4'b0, '0, 4'b0);
        #1;
        check("lat next o_valid", 128'(bus.o_valid), 128'(4'b0011));
        check("lat next data0", 128'(bus.o_data[0]), 128'(bd(16'h0E1)));
        check("lat next data1", 128'(bus.o_data[1]), 128'(bd(16'h0E2)));
        check("lat next count", 128'(bus.o_count), 128'(2));
`endif
        rstn = 1'b0;
        #1;
        check("async rst o_valid", 128'(bus.o_valid), 128'(0));
        check("async rst count", 128'(bus.o_count), 128'(0));
        check("async rst i_ready", 128'(bus.i_ready), 128'(1));
        model.delete();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        run_cycle(1'b0, 4'b1000, {16'h0F0, D, D, D}, 4'b0000, "post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
